trans_mem_bank: RTL and testbench



---
 rtl/trans_mem_bank.sv | 84 ++++++++
 tb/tb_trans_mem_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trans_mem_bank.sv
// Multi-channel transaction memory: NUM_CH independent DEPTH x DATA_W banks, each with
// an auto-incrementing write pointer, a registered addressed read port and occupancy status.
module trans_mem_bank #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int WRAP_MODE = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            tm_cnt_en,
    input  logic [NUM_CH*DATA_W-1:0]     tm_dina,
    input  logic [NUM_CH-1:0]            tm_clr,
    input  logic [NUM_CH*ADDR_W-1:0]     tm_addrb,
    input  logic [NUM_CH-1:0]            tm_renb,
    output logic [NUM_CH*DATA_W-1:0]     tm_doutb,
    output logic [NUM_CH*(ADDR_W+1)-1:0] tm_count,
    output logic [NUM_CH-1:0]            tm_full,
    output logic [NUM_CH-1:0]            tm_overflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic              WRAP_EN  = (WRAP_MODE != 0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] wr_ptr;
        logic [ADDR_W-1:0] next_ptr;
        logic [ADDR_W:0]   count;
        logic              overflow;
        logic              full;
        logic              do_write;
        logic [DATA_W-1:0] doutb;
        logic [DATA_W-1:0] din;
        logic [ADDR_W-1:0] addrb;

        assign din      = tm_dina[c*DATA_W +: DATA_W];
        assign addrb    = tm_addrb[c*ADDR_W +: ADDR_W];
        assign full     = (count == FULL_CNT);
        assign next_ptr = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        assign do_write = tm_cnt_en[c] & ~tm_clr[c] & (~full | WRAP_EN);

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (tm_clr[c]) begin
                wr_ptr   <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else if (tm_cnt_en[c]) begin
                if (!full) begin
                    wr_ptr <= next_ptr;
                    count  <= count + 1'b1;
                end else begin
                    overflow <= 1'b1;
                    if (WRAP_EN) wr_ptr <= next_ptr;
                end
            end
        end

        // Array has no reset; a write landing during reset is hidden by the zeroed count.
        always_ff @(posedge clock) begin
            if (do_write) mem[wr_ptr] <= din;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                doutb <= '0;
            end else if (tm_renb[c]) begin
                doutb <= ({1'b0, addrb} < count) ? mem[addrb] : '0;
            end
        end

        assign tm_doutb[c*DATA_W +: DATA_W]         = doutb;
        assign tm_count[c*(ADDR_W+1) +: ADDR_W + 1] = count;
        assign tm_full[c]                           = full;
        assign tm_overflow[c]                       = overflow;
    end

endmodule

// File: tb/tb_trans_mem_bank.sv
// Bench for trans_mem_bank: a stop-mode and a wrap-mode instance share stimulus and are
// compared each cycle against a write-history model of every channel.
module tb_trans_mem_bank;

    localparam int NCH   = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [NCH-1:0]  tm_cnt_en;
    logic [NCH*DW-1:0] tm_dina;
    logic [NCH-1:0]  tm_clr;
    logic [NCH*AW-1:0] tm_addrb;
    logic [NCH-1:0]  tm_renb;

    logic [NCH*DW-1:0]     dout_s, dout_w;
    logic [NCH*(AW+1)-1:0] count_s, count_w;
    logic [NCH-1:0]        full_s, full_w, ovf_s, ovf_w;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;

    // Model: per (instance, channel) the ordered list of write attempts since reset/clear.
    logic [7:0] hist [4][$];
    logic [7:0] exp_dout [4];

    trans_mem_bank #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .WRAP_MODE(0)) dut_stop (
        .clock(clock), .reset(reset), .tm_cnt_en(tm_cnt_en), .tm_dina(tm_dina),
        .tm_clr(tm_clr), .tm_addrb(tm_addrb), .tm_renb(tm_renb), .tm_doutb(dout_s),
        .tm_count(count_s), .tm_full(full_s), .tm_overflow(ovf_s)
    );

    trans_mem_bank #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .WRAP_MODE(1)) dut_wrap (
        .clock(clock), .reset(reset), .tm_cnt_en(tm_cnt_en), .tm_dina(tm_dina),
        .tm_clr(tm_clr), .tm_addrb(tm_addrb), .tm_renb(tm_renb), .tm_doutb(dout_w),
        .tm_count(count_w), .tm_full(full_w), .tm_overflow(ovf_w)
    );

    always #5 clock = ~clock;

    function automatic int model_count(input int i);
        return (hist[i].size() < DEPTH) ? hist[i].size() : DEPTH;
    endfunction

    function automatic logic [7:0] model_read(input int i, input int a);
        int n;
        n = hist[i].size();
        if (a >= model_count(i)) return 8'h00;
        if (i < 2) return hist[i][a];
        return hist[i][a + DEPTH * ((n - 1 - a) / DEPTH)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hist[i].delete();
            exp_dout[i] = 8'h00;
        end
    endtask

    // Reads see pre-edge state, then clear or write attempt is applied.
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            int c;
            c = i % 2;
            if (tm_renb[c]) exp_dout[i] = model_read(i, int'(tm_addrb[c*AW +: AW]));
            if (tm_clr[c]) hist[i].delete();
            else if (tm_cnt_en[c]) hist[i].push_back(tm_dina[c*DW +: DW]);
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        check_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            int c;
            logic [7:0] d;
            logic [4:0] n;
            logic f, o;
            string nm;
            c  = i % 2;
            nm = $sformatf("%s_ch%0d", (i < 2) ? "stop" : "wrap", c);
            d  = (i < 2) ? dout_s[c*DW +: DW]    : dout_w[c*DW +: DW];
            n  = (i < 2) ? count_s[c*5 +: 5]     : count_w[c*5 +: 5];
            f  = (i < 2) ? full_s[c]             : full_w[c];
            o  = (i < 2) ? ovf_s[c]              : ovf_w[c];
            check_output({nm, "_doutb"},    32'(d), 32'(exp_dout[i]));
            check_output({nm, "_count"},    32'(n), 32'(model_count(i)));
            check_output({nm, "_full"},     32'(f), 32'(model_count(i) == DEPTH));
            check_output({nm, "_overflow"}, 32'(o), 32'(hist[i].size() > DEPTH));
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        tm_cnt_en = '0;
        tm_clr    = '0;
        tm_renb   = '0;
    endtask

    initial begin
        logic [7:0] ch0_vals [4];
        logic [7:0] ch1_vals [4];
        ch0_vals = '{8'h12, 8'h1D, 8'h1D, 8'h1B};
        ch1_vals = '{8'hBA, 8'h1D, 8'h00, 8'h01};

        reset    = 1'b1;
        tm_dina  = '0;
        tm_addrb = '0;
        idle_inputs();
        model_reset();
        #499;
        check_all();
        #1 reset = 1'b0;

        $display("[TB] basic readback");
        for (int k = 0; k < 4; k++) begin
            tm_cnt_en = 2'b11;
            tm_dina   = {ch1_vals[k], ch0_vals[k]};
            apply_stimulus();
        end
        idle_inputs();
        tm_renb = 2'b11;
        for (int a = 0; a < 4; a++) begin
            tm_addrb = {AW'(a), AW'(a)};
            apply_stimulus();
            check_output("readback_ch0", 32'(dout_s[7:0]), 32'(ch0_vals[a]));
            check_output("readback_ch1", 32'(dout_s[15:8]), 32'(ch1_vals[a]));
        end
        check_output("readback_count", 32'(count_s), 32'({5'd4, 5'd4}));

        $display("[TB] unwritten mask and hold");
        tm_addrb = {AW'(0), AW'(5)};
        apply_stimulus();
        check_output("unwritten_addr5", 32'(dout_s[7:0]), 32'h00);
        tm_renb  = 2'b00;
        tm_addrb = {AW'(1), AW'(2)};
        apply_stimulus();
        check_output("hold_no_renb", 32'(dout_s[7:0]), 32'h00);

        $display("[TB] fill past full");
        tm_clr = 2'b01;
        apply_stimulus();
        tm_clr = 2'b00;
        for (int k = 0; k < 18; k++) begin
            tm_cnt_en = 2'b01;
            tm_dina   = {8'h00, 8'(k)};
            apply_stimulus();
            if (k == 15) begin
                check_output("stop_full_at16", 32'(full_s[0]), 32'h1);
                check_output("stop_ovf_at16", 32'(ovf_s[0]), 32'h0);
            end
        end
        check_output("stop_ovf_after", 32'(ovf_s[0]), 32'h1);
        check_output("wrap_count_after", 32'(count_w[4:0]), 32'd16);
        idle_inputs();
        tm_renb = 2'b01;
        for (int a = 0; a < 3; a++) begin
            logic [7:0] wrap_exp [3];
            wrap_exp = '{8'h10, 8'h11, 8'h02};
            tm_addrb = {AW'(0), AW'(a)};
            apply_stimulus();
            check_output("stop_keep_old", 32'(dout_s[7:0]), 32'(a));
            check_output("wrap_overwrite", 32'(dout_w[7:0]), 32'(wrap_exp[a]));
        end

        $display("[TB] clear versus write collision");
        idle_inputs();
        tm_clr = 2'b01;
        apply_stimulus();
        tm_clr = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tm_cnt_en = 2'b01;
            tm_dina   = {8'h00, 8'h30 + 8'(k)};
            apply_stimulus();
        end
        tm_clr  = 2'b01;
        tm_dina = {8'h00, 8'hAA};
        apply_stimulus();
        check_output("collide_count", 32'(count_s[4:0]), 32'd0);
        idle_inputs();
        tm_renb  = 2'b01;
        tm_addrb = {AW'(0), AW'(0)};
        apply_stimulus();
        check_output("collide_read0", 32'(dout_s[7:0]), 32'h00);
        tm_renb   = 2'b00;
        tm_cnt_en = 2'b01;
        apply_stimulus();
        tm_cnt_en = 2'b00;
        tm_renb   = 2'b01;
        apply_stimulus();
        check_output("collide_rewrite", 32'(dout_s[7:0]), 32'hAA);

        $display("[TB] async reset mid-stream");
        for (int k = 0; k < 3; k++) begin
            tm_cnt_en = 2'b11;
            tm_renb   = 2'b11;
            tm_dina   = 16'($urandom);
            tm_addrb  = {AW'(k), AW'(0)};
            apply_stimulus();
        end
        #2 reset = 1'b1;
        #1;
        check_output("reset_doutb", 32'({dout_s, dout_w}), 32'h0);
        check_output("reset_count", 32'({count_s, count_w}), 32'h0);
        check_output("reset_full_ovf", 32'({full_s, full_w, ovf_s, ovf_w}), 32'h0);
        #2 reset = 1'b0;
        model_reset();
        idle_inputs();
        tm_renb = 2'b11;
        for (int a = 0; a < 3; a++) begin
            tm_addrb = {AW'(a), AW'(a)};
            apply_stimulus();
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < NCH; c++) begin
                tm_cnt_en[c] = ($urandom_range(0, 9) < 7);
                tm_clr[c]    = ($urandom_range(0, 39) == 0);
                tm_renb[c]   = ($urandom_range(0, 1) == 1);
                tm_addrb[c*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
                tm_dina[c*DW +: DW]  = DW'($urandom);
            end
            apply_stimulus();
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
